// File: rtl/clk_div_pkg.sv
// Shared types and default parameters for the divided-clock period monitor.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int CNT_W_DEF   = 16;
    localparam int LOG2_W_DEF  = 4;
    localparam int LOCK_N_DEF  = 4;
    localparam int TIMEOUT_DEF = 65535;

    // Divide setting the PLL divider register is programmed with at bring-up.
    localparam int CLK_PLL_DIV_REG   = 3;
    localparam int EXPECTED_LOG2_DEF = CLK_PLL_DIV_REG;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by rising-edge detection.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic sync1_q, sync2_q, sync3_q;
    logic sync1_d, sync2_d, sync3_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of a divided clock in clk_hf cycles and reports lock,
// mismatch and timeout against an expected power-of-two ratio.
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int LOG2_W  = LOG2_W_DEF,
    parameter int LOCK_N  = LOCK_N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_hf,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clk_div_in,
    input  logic [LOG2_W-1:0] expected_log2,
    output logic [CNT_W-1:0]  period_count,
    output logic              period_valid,
    output logic              locked,
    output logic              mismatch,
    output logic              timeout
);

    localparam int MC_W = 4;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  LOCK_C    = MC_W'(LOCK_N);

    logic rise;

    sync_edge_det u_sync (
        .clk   (clk_hf),
        .rst_n (rst_n),
        .din   (clk_div_in),
        .rise  (rise)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  period_count_q, period_count_d;
    logic              period_valid_q, period_valid_d;
    logic              locked_q, locked_d;
    logic              mismatch_q, mismatch_d;
    logic              timeout_q, timeout_d;

    logic              exp_reachable;
    logic [CNT_W-1:0]  exp_period;
    logic              period_match;
    logic [CNT_W-1:0]  cnt_inc;

    // A ratio wider than the counter can never be measured, so it always mismatches.
    always_comb begin
        exp_reachable = int'(expected_log2) < CNT_W;
        exp_period    = exp_reachable ? (CNT_W'(1) << expected_log2) : '0;
        period_match  = exp_reachable && (cnt_q == exp_period);
        cnt_inc       = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        match_cnt_d    = match_cnt_q;
        period_count_d = period_count_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        mismatch_d     = 1'b0;
        timeout_d      = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            match_cnt_d = '0;
            locked_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = ACQUIRE;
                    cnt_d       = '0;
                    match_cnt_d = '0;
                    locked_d    = 1'b0;
                end
                ACQUIRE: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = MEASURE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEASURE: begin
                    // An edge landing on the timeout count is still a valid measurement.
                    if (rise) begin
                        period_count_d = cnt_q;
                        period_valid_d = 1'b1;
                        cnt_d          = CNT_W'(1);
                        if (period_match) begin
                            if (match_cnt_q != LOCK_C) begin
                                match_cnt_d = match_cnt_q + MC_W'(1);
                            end
                            if (match_cnt_d == LOCK_C) begin
                                locked_d = 1'b1;
                            end
                        end else begin
                            mismatch_d  = 1'b1;
                            locked_d    = 1'b0;
                            match_cnt_d = '0;
                        end
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                        cnt_d       = '0;
                        state_d     = ACQUIRE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_hf or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            match_cnt_q    <= '0;
            period_count_q <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            mismatch_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            match_cnt_q    <= match_cnt_d;
            period_count_q <= period_count_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            mismatch_q     <= mismatch_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period_count = period_count_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign mismatch     = mismatch_q;
    assign timeout      = timeout_q;

endmodule
